// File: rtl/cmd_decoder.sv
// DDR4 command decoder with per-bank row/column/burst tracking; decode is combinational, bank state registers on clk.
// Define DDR3_EN for DDR3 pin decoding (explicit ras_n/cas_n/we_n, act_n ignored, 011 = ACT).
module cmd_decoder #(
  parameter int ADDRWIDTH     = 17,
  parameter int COLWIDTH      = 10,
  parameter int BGWIDTH       = 2,
  parameter int BANKGROUPS    = 2**BGWIDTH,
  parameter int BAWIDTH       = 2,
  parameter int BANKSPERGROUP = 2**BAWIDTH,
  parameter int BL            = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cke,
  input  logic                 cs_n,
  input  logic                 act_n,
  input  logic [BGWIDTH-1:0]   bg,
  input  logic [BAWIDTH-1:0]   ba,
  input  logic [ADDRWIDTH-1:0] A,
`ifdef DDR3_EN
  input  logic                 ras_n,
  input  logic                 cas_n,
  input  logic                 we_n,
`endif
  output logic [ADDRWIDTH-1:0] RowId   [BANKGROUPS][BANKSPERGROUP],
  output logic [COLWIDTH-1:0]  ColId   [BANKGROUPS][BANKSPERGROUP],
  output logic                 rd_o_wr [BANKGROUPS][BANKSPERGROUP],
  output logic [18:0]          commands
);

  localparam int C_DES = 0,  C_NOP = 1,  C_ACT = 2,  C_RD = 3,   C_RDA = 4;
  localparam int C_WR = 5,   C_WRA = 6,  C_PRE = 7,  C_PREA = 8, C_REF = 9;
  localparam int C_SRE = 10, C_SRX = 11, C_PDE = 12, C_PDX = 13, C_MRS = 14;
  localparam int C_ZQCL = 15, C_ZQCS = 16, C_RFU = 17, C_ILLEGAL = 18;

  localparam int CNTW = (BL > 1) ? $clog2(BL) : 1;
  localparam logic [COLWIDTH-1:0] BL_MASK = COLWIDTH'(BL - 1);

  logic cke_prev;
  logic sr_flag;
  logic ACT, RD, WR, PR;
  logic Burst [BANKGROUPS][BANKSPERGROUP];
  logic [CNTW-1:0] cnt [BANKGROUPS][BANKSPERGROUP];

  logic [2:0] rcw;
  logic       act_cmd;
  logic       pat_qual;
  logic       des_pat, nop_pat, ref_pat;

`ifdef DDR3_EN
  assign rcw      = {ras_n, cas_n, we_n};
  assign act_cmd  = !cs_n && (rcw == 3'b011);
  assign pat_qual = 1'b1;
`else
  assign rcw      = A[16:14];
  assign act_cmd  = !cs_n && !act_n;
  assign pat_qual = act_n;
`endif

  assign des_pat = cs_n;
  assign nop_pat = !cs_n && pat_qual && (rcw == 3'b111);
  assign ref_pat = !cs_n && pat_qual && (rcw == 3'b001);

  always_comb begin
    commands = '0;
    case ({cke_prev, cke})
      2'b11: begin
        if (cs_n) commands[C_DES] = 1'b1;
        else if (act_cmd) commands[C_ACT] = 1'b1;
        else begin
          case (rcw)
            3'b000:  commands[C_MRS] = 1'b1;
            3'b001:  commands[C_REF] = 1'b1;
            3'b010:  commands[A[10] ? C_PREA : C_PRE] = 1'b1;
            3'b011:  commands[C_RFU] = 1'b1;
            3'b100:  commands[A[10] ? C_WRA : C_WR] = 1'b1;
            3'b101:  commands[A[10] ? C_RDA : C_RD] = 1'b1;
            3'b110:  commands[A[10] ? C_ZQCL : C_ZQCS] = 1'b1;
            default: commands[C_NOP] = 1'b1;
          endcase
        end
      end
      2'b10: begin
        if (ref_pat) commands[C_SRE] = 1'b1;
        else if (des_pat || nop_pat) commands[C_PDE] = 1'b1;
        else commands[C_ILLEGAL] = 1'b1;
      end
      2'b01: begin
        if (des_pat || nop_pat) commands[sr_flag ? C_SRX : C_PDX] = 1'b1;
        else commands[C_ILLEGAL] = 1'b1;
      end
      default: commands = '0;
    endcase
  end

  assign ACT = commands[C_ACT];
  assign RD  = commands[C_RD] | commands[C_RDA];
  assign WR  = commands[C_WR] | commands[C_WRA];
  assign PR  = commands[C_PRE] | commands[C_PREA];

  always_ff @(posedge clk) begin
    if (rst) begin
      cke_prev <= 1'b1;
      sr_flag  <= 1'b0;
    end else begin
      cke_prev <= cke;
      if (commands[C_SRE]) sr_flag <= 1'b1;
      else if (commands[C_SRX]) sr_flag <= 1'b0;
    end
  end

  // A new RD/WR to a bank wins over precharge and burst advance for that bank.
  always_ff @(posedge clk) begin
    for (int g = 0; g < BANKGROUPS; g++) begin
      for (int b = 0; b < BANKSPERGROUP; b++) begin
        if (rst) begin
          RowId[g][b]   <= '0;
          ColId[g][b]   <= '0;
          rd_o_wr[g][b] <= 1'b0;
          Burst[g][b]   <= 1'b0;
          cnt[g][b]     <= '0;
        end else begin
          if (ACT && bg == BGWIDTH'(g) && ba == BAWIDTH'(b))
            RowId[g][b] <= A;
          if ((RD || WR) && bg == BGWIDTH'(g) && ba == BAWIDTH'(b)) begin
            ColId[g][b]   <= A[COLWIDTH-1:0];
            Burst[g][b]   <= 1'b1;
            rd_o_wr[g][b] <= WR;
            cnt[g][b]     <= '0;
          end else if (commands[C_PREA] ||
                       (commands[C_PRE] && bg == BGWIDTH'(g) && ba == BAWIDTH'(b))) begin
            Burst[g][b]   <= 1'b0;
            rd_o_wr[g][b] <= 1'b0;
          end else if (Burst[g][b]) begin
            if (cnt[g][b] < CNTW'(BL - 1)) begin
              cnt[g][b]   <= cnt[g][b] + 1'b1;
              ColId[g][b] <= (ColId[g][b] & ~BL_MASK) | ((ColId[g][b] + 1'b1) & BL_MASK);
            end else begin
              Burst[g][b] <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed bench for cmd_decoder: table-driven decode checks plus burst, precharge and power-state sequences.
module tb_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cke, cs_n, act_n;
  logic [1:0]  bg, ba;
  logic [16:0] A;
  logic [16:0] RowId   [4][4];
  logic [9:0]  ColId   [4][4];
  logic        rd_o_wr [4][4];
  logic [18:0] commands;

  int n_chk  = 0;
  int n_fail = 0;

  cmd_decoder dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .act_n(act_n),
    .bg(bg), .ba(ba), .A(A),
    .RowId(RowId), .ColId(ColId), .rd_o_wr(rd_o_wr), .commands(commands)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cs_n;
    logic        act_n;
    logic [16:0] a;
    logic [18:0] exp_cmd;
    logic [3:0]  exp_grp;  // {ACT, RD, WR, PR}
  } vec_t;

  vec_t tbl [14];
  int   wrap_exp [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive on the falling edge, then settle so combinational outputs can be checked.
  task automatic apply(input logic k, input logic cs, input logic an,
                       input logic [1:0] g, input logic [1:0] b, input logic [16:0] a);
    @(negedge clk);
    cke = k; cs_n = cs; act_n = an; bg = g; ba = b; A = a;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 17'h00000, 19'd1 << 0,  4'b0000};
    tbl[1]  = '{1'b0, 1'b0, 17'h00001, 19'd1 << 2,  4'b1000};
    tbl[2]  = '{1'b0, 1'b1, 17'h00000, 19'd1 << 14, 4'b0000};
    tbl[3]  = '{1'b0, 1'b1, 17'h04000, 19'd1 << 9,  4'b0000};
    tbl[4]  = '{1'b0, 1'b1, 17'h08000, 19'd1 << 7,  4'b0001};
    tbl[5]  = '{1'b0, 1'b1, 17'h08400, 19'd1 << 8,  4'b0001};
    tbl[6]  = '{1'b0, 1'b1, 17'h0C000, 19'd1 << 17, 4'b0000};
    tbl[7]  = '{1'b0, 1'b1, 17'h10000, 19'd1 << 5,  4'b0010};
    tbl[8]  = '{1'b0, 1'b1, 17'h10400, 19'd1 << 6,  4'b0010};
    tbl[9]  = '{1'b0, 1'b1, 17'h14000, 19'd1 << 3,  4'b0100};
    tbl[10] = '{1'b0, 1'b1, 17'h14400, 19'd1 << 4,  4'b0100};
    tbl[11] = '{1'b0, 1'b1, 17'h18000, 19'd1 << 16, 4'b0000};
    tbl[12] = '{1'b0, 1'b1, 17'h18400, 19'd1 << 15, 4'b0000};
    tbl[13] = '{1'b0, 1'b1, 17'h1C000, 19'd1 << 1,  4'b0000};
    wrap_exp = '{13, 14, 15, 8, 9, 10, 11, 12};

    rst = 1'b1; cke = 1'b1; cs_n = 1'b1; act_n = 1'b1; bg = 2'd0; ba = 2'd0; A = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    apply(1, 1, 1, 0, 1, 17'h0);
    chk("reset_cmd", 32'(commands), 32'h1);
    chk("reset_row", 32'(RowId[0][1]), 0);
    chk("reset_col", 32'(ColId[0][1]), 0);
    chk("reset_burst", 32'(dut.Burst[0][1]), 0);
    chk("reset_rdwr", 32'(rd_o_wr[0][1]), 0);
    tick();

    // Decode table in steady cke=1
    for (int i = 0; i < 14; i++) begin
      apply(1, tbl[i].cs_n, tbl[i].act_n, 0, 0, tbl[i].a);
      chk($sformatf("decode_cmd[%0d]", i), 32'(commands), 32'(tbl[i].exp_cmd));
      chk($sformatf("decode_grp[%0d]", i), 32'({dut.ACT, dut.RD, dut.WR, dut.PR}), 32'(tbl[i].exp_grp));
      tick();
    end
    for (int i = 0; i < 10; i++) begin apply(1, 1, 1, 0, 0, 17'h0); tick(); end

    // ACT latches row
    apply(1, 0, 0, 0, 1, 17'h00001);
    chk("act_flag", 32'(dut.ACT), 1);
    chk("act_cmd", 32'(commands), 32'h4);
    tick();
    chk("act_row", 32'(RowId[0][1]), 1);

    // WR burst with MRS filler cycles
    apply(1, 0, 1, 0, 1, 17'h10008);
    chk("wr_flag", 32'(dut.WR), 1);
    tick();
    chk("wr_col[0]", 32'(ColId[0][1]), 8);
    chk("wr_burst[0]", 32'(dut.Burst[0][1]), 1);
    chk("wr_dir[0]", 32'(rd_o_wr[0][1]), 1);
    for (int i = 1; i < 8; i++) begin
      apply(1, 0, 1, 0, 0, 17'h0);
      tick();
      chk($sformatf("wr_col[%0d]", i), 32'(ColId[0][1]), 32'(8 + i));
      chk($sformatf("wr_burst[%0d]", i), 32'(dut.Burst[0][1]), 1);
      chk($sformatf("wr_dir[%0d]", i), 32'(rd_o_wr[0][1]), 1);
    end
    apply(1, 1, 1, 0, 0, 17'h0);
    tick();
    chk("wr_burst_end", 32'(dut.Burst[0][1]), 0);
    chk("wr_col_hold", 32'(ColId[0][1]), 15);

    // RD burst
    apply(1, 0, 1, 0, 1, 17'h14008);
    chk("rd_flag", 32'(dut.RD), 1);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rd_col[%0d]", i), 32'(ColId[0][1]), 32'(8 + i));
      chk($sformatf("rd_burst[%0d]", i), 32'(dut.Burst[0][1]), 1);
      chk($sformatf("rd_dir[%0d]", i), 32'(rd_o_wr[0][1]), 0);
      apply(1, 1, 1, 0, 0, 17'h0);
      tick();
    end
    chk("rd_burst_end", 32'(dut.Burst[0][1]), 0);

    // PRE on a bank mid-write-burst
    apply(1, 0, 1, 0, 1, 17'h10008);
    tick();
    apply(1, 0, 1, 0, 1, 17'h08000);
    chk("pre_flag", 32'(dut.PR), 1);
    tick();
    chk("pre_burst", 32'(dut.Burst[0][1]), 0);
    chk("pre_dir", 32'(rd_o_wr[0][1]), 0);
    chk("pre_row_hold", 32'(RowId[0][1]), 1);
    chk("pre_col_hold", 32'(ColId[0][1]), 8);

    // PREA with two independent bursts running
    apply(1, 0, 1, 0, 1, 17'h10000);
    tick();
    apply(1, 0, 1, 1, 2, 17'h10004);
    tick();
    chk("prea_pre_b01", 32'(dut.Burst[0][1]), 1);
    chk("prea_pre_c01", 32'(ColId[0][1]), 1);
    chk("prea_pre_b12", 32'(dut.Burst[1][2]), 1);
    chk("prea_pre_c12", 32'(ColId[1][2]), 4);
    apply(1, 0, 1, 0, 0, 17'h08400);
    chk("prea_flag", 32'(commands), 32'h100);
    tick();
    chk("prea_b01", 32'(dut.Burst[0][1]), 0);
    chk("prea_b12", 32'(dut.Burst[1][2]), 0);
    chk("prea_d01", 32'(rd_o_wr[0][1]), 0);
    chk("prea_d12", 32'(rd_o_wr[1][2]), 0);
    chk("prea_c12_hold", 32'(ColId[1][2]), 4);

    // Column wrap within BL-aligned block
    apply(1, 0, 1, 0, 1, 17'h1000D);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wrap_col[%0d]", i), 32'(ColId[0][1]), 32'(wrap_exp[i]));
      apply(1, 1, 1, 0, 0, 17'h0);
      tick();
    end
    chk("wrap_end", 32'(dut.Burst[0][1]), 0);

    // Restart: new RD to a bank already bursting
    apply(1, 0, 1, 0, 2, 17'h10010);
    tick();
    apply(1, 1, 1, 0, 0, 17'h0);
    tick();
    chk("restart_mid", 32'(ColId[0][2]), 17);
    apply(1, 0, 1, 0, 2, 17'h14014);
    tick();
    chk("restart_col", 32'(ColId[0][2]), 20);
    chk("restart_dir", 32'(rd_o_wr[0][2]), 0);
    chk("restart_burst", 32'(dut.Burst[0][2]), 1);
    apply(1, 1, 1, 0, 0, 17'h0);
    tick();
    chk("restart_next", 32'(ColId[0][2]), 21);
    for (int i = 0; i < 8; i++) begin apply(1, 1, 1, 0, 0, 17'h0); tick(); end

    // Power state transitions
    apply(0, 0, 1, 0, 0, 17'h04000);
    chk("sre", 32'(commands), 32'h400);
    tick();
    apply(0, 1, 1, 0, 0, 17'h0);
    chk("cke_low_idle", 32'(commands), 0);
    tick();
    apply(1, 1, 1, 0, 0, 17'h0);
    chk("srx", 32'(commands), 32'h800);
    tick();
    apply(0, 1, 1, 0, 0, 17'h0);
    chk("pde", 32'(commands), 32'h1000);
    tick();
    apply(1, 1, 1, 0, 0, 17'h0);
    chk("pdx", 32'(commands), 32'h2000);
    tick();
    apply(0, 0, 0, 0, 0, 17'h0);
    chk("illegal_entry", 32'(commands), 32'h40000);
    tick();
    apply(1, 0, 1, 0, 3, 17'h14000);
    chk("illegal_exit", 32'(commands), 32'h40000);
    chk("illegal_no_rd", 32'(dut.RD), 0);
    tick();
    chk("illegal_no_burst", 32'(dut.Burst[0][3]), 0);

    // Reset overrides a burst in progress
    apply(1, 0, 1, 1, 1, 17'h10003);
    tick();
    chk("rstb_pre", 32'(dut.Burst[1][1]), 1);
    @(negedge clk);
    rst = 1'b1;
    cs_n = 1'b1;
    tick();
    chk("rstb_burst", 32'(dut.Burst[1][1]), 0);
    chk("rstb_col", 32'(ColId[1][1]), 0);
    chk("rstb_row", 32'(RowId[0][1]), 0);
    @(negedge clk);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
